// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit
//  Description : Hazard controller for a 5-stage MIPS pipeline. Tracks the
//                destination registers of the instructions in EX and MEM,
//                generates registered operand-forwarding selects for the
//                instruction entering EX, and raises a one-cycle load-use
//                stall that also injects a bubble into EX.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk          rising-edge clock
//    i_rst_n        synchronous reset, active-low
//    i_valid        ID instruction is real (0 = bubble)
//    i_rs / i_rt    ID source registers A / B
//    i_dst          ID destination register (after RegDst mux)
//    i_reg_write    ID instruction writes the register file
//    i_mem_read     ID instruction is a load
//    i_flush        squash the ID instruction (taken branch/jump)
//    o_fwd_a/b      operand A/B mux select for the instruction in EX
//                   (00 = register file, 01 = MEM/WB, 10 = EX/MEM)
//    o_stall        hold PC and IF/ID this cycle (combinational)
//    o_stall_count  [FWD_STATS_EN only] saturating count of effective stalls
//
//  Build option
//    FWD_STATS_EN   when defined, adds o_stall_count.
// ============================================================================
module forwarding_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_dst,
    input  logic                      i_reg_write,
    input  logic                      i_mem_read,
    input  logic                      i_flush,
    output logic [1:0]                o_fwd_a,
    output logic [1:0]                o_fwd_b,
    output logic                      o_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               o_stall_count
`endif
);

    localparam logic [1:0] c_SEL_RF    = 2'b00;
    localparam logic [1:0] c_SEL_MEMWB = 2'b01;
    localparam logic [1:0] c_SEL_EXMEM = 2'b10;

    localparam logic [REG_ADDR_WIDTH-1:0] c_REG_ZERO = '0;

    // Tracking slots. Only what drives forwarding or stalls is stored: the
    // load flag matters only in EX, and the WB-stage writer is covered by the
    // register file's write-before-read, so nothing past MEM needs tracking.
    logic [REG_ADDR_WIDTH-1:0] r_ex_dst_q,  w_ex_dst_d;
    logic                      r_ex_we_q,   w_ex_we_d;
    logic                      r_ex_mr_q,   w_ex_mr_d;
    logic [REG_ADDR_WIDTH-1:0] r_mem_dst_q, w_mem_dst_d;
    logic                      r_mem_we_q,  w_mem_we_d;
    logic [1:0]                r_fwd_a_q,   w_fwd_a_d;
    logic [1:0]                r_fwd_b_q,   w_fwd_b_d;

    logic w_stall;
    logic w_load_ex;

    // Most recent writer wins: EX slot (moving to MEM) beats MEM slot.
    function automatic logic [1:0] f_sel(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic                      ex_we,
        input logic [REG_ADDR_WIDTH-1:0] ex_dst,
        input logic                      mem_we,
        input logic [REG_ADDR_WIDTH-1:0] mem_dst
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (src != c_REG_ZERO) begin
            if (ex_we && (ex_dst == src)) begin
                sel = c_SEL_EXMEM;
            end else if (mem_we && (mem_dst == src)) begin
                sel = c_SEL_MEMWB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        // A real load in EX whose destination is read by the ID instruction.
        w_stall = i_valid && r_ex_mr_q && r_ex_we_q && (r_ex_dst_q != c_REG_ZERO) &&
                  ((r_ex_dst_q == i_rs) || (r_ex_dst_q == i_rt));

        // Flush and stall both turn the EX entry into a bubble.
        w_load_ex = i_valid && !w_stall && !i_flush;

        w_mem_dst_d = r_ex_dst_q;
        w_mem_we_d  = r_ex_we_q;

        w_ex_dst_d = '0;
        w_ex_we_d  = 1'b0;
        w_ex_mr_d  = 1'b0;
        w_fwd_a_d  = c_SEL_RF;
        w_fwd_b_d  = c_SEL_RF;
        if (w_load_ex) begin
            w_ex_dst_d = i_dst;
            w_ex_we_d  = i_reg_write;
            w_ex_mr_d  = i_mem_read;
            w_fwd_a_d  = f_sel(i_rs, r_ex_we_q, r_ex_dst_q, r_mem_we_q, r_mem_dst_q);
            w_fwd_b_d  = f_sel(i_rt, r_ex_we_q, r_ex_dst_q, r_mem_we_q, r_mem_dst_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex_dst_q  <= '0;
            r_ex_we_q   <= 1'b0;
            r_ex_mr_q   <= 1'b0;
            r_mem_dst_q <= '0;
            r_mem_we_q  <= 1'b0;
            r_fwd_a_q   <= c_SEL_RF;
            r_fwd_b_q   <= c_SEL_RF;
        end else begin
            r_ex_dst_q  <= w_ex_dst_d;
            r_ex_we_q   <= w_ex_we_d;
            r_ex_mr_q   <= w_ex_mr_d;
            r_mem_dst_q <= w_mem_dst_d;
            r_mem_we_q  <= w_mem_we_d;
            r_fwd_a_q   <= w_fwd_a_d;
            r_fwd_b_q   <= w_fwd_b_d;
        end
    end

    assign o_fwd_a = r_fwd_a_q;
    assign o_fwd_b = r_fwd_b_q;
    assign o_stall = w_stall;

`ifdef FWD_STATS_EN
    logic [31:0] r_stall_count_q, w_stall_count_d;

    // A stall coinciding with a flush holds nothing useful, so it is not counted.
    always_comb begin
        w_stall_count_d = r_stall_count_q;
        if (w_stall && !i_flush && (r_stall_count_q != 32'hFFFF_FFFF)) begin
            w_stall_count_d = r_stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_count_q <= '0;
        end else begin
            r_stall_count_q <= w_stall_count_d;
        end
    end

    assign o_stall_count = r_stall_count_q;
`endif

endmodule
`default_nettype wire
